// File: rtl/bus_sched_pkg.sv
// bus_sched_pkg: shared state encoding and constants
// for the 7501-side bus cycle scheduler.
package bus_sched_pkg;

   typedef enum logic [2:0] {
      SYNC,
      LOW,
      OWN,
      STALL,
      ABORT
   } state_t;

   localparam logic BUS_R_W_RST    = 1'b1;
   localparam logic BUS_OE_RST     = 1'b0;
   localparam int   LATCH_LEAD_DEF = 2;

endpackage

// File: rtl/bus_cycle_sched_phase_sync.sv
// phase_sync: multi-flop synchroniser for an asynchronous
// input, plus rise/fall detection on the synchronised level.
module phase_sync
   import bus_sched_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic _reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         prev  <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/bus_cycle_sched.sv
// bus_cycle_sched: owns the 7501 bus per phi0 cycle for the soft 6502.
// Optional stall statistics counter enabled by defining STALL_STATS_EN.
module bus_cycle_sched
   import bus_sched_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int LEN_W       = 6,
   parameter int LATCH_LEAD  = LATCH_LEAD_DEF,
   parameter int STALL_W     = 10
) (
   input  logic               clk,
   input  logic               _reset,
   input  logic               phi0_in,
   input  logic               aec,
   input  logic               core_r_w,
   output logic               core_ce,
   output logic               bus_oe,
   output logic               bus_r_w,
   output logic               rd_strobe,
   output logic               cycle_abort,
   output logic [STALL_W-1:0] stall_cnt
);

   localparam logic [LEN_W-1:0] LEAD = LEN_W'(LATCH_LEAD);
   localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

   state_t           state;
   logic             phi, phi_rise, phi_fall;
   logic             aec_q, aec_rise, aec_fall;
   logic             unused_edges;
   logic [LEN_W-1:0] hi_count, hi_len, target, pre_hit;

   phase_sync #(.STAGES(SYNC_STAGES)) u_phi (
      .clk    (clk),
      ._reset (_reset),
      .d      (phi0_in),
      .q      (phi),
      .rise   (phi_rise),
      .fall   (phi_fall)
   );

   phase_sync #(.STAGES(SYNC_STAGES)) u_aec (
      .clk    (clk),
      ._reset (_reset),
      .d      (aec),
      .q      (aec_q),
      .rise   (aec_rise),
      .fall   (aec_fall)
   );

   assign unused_edges = aec_rise ^ aec_fall;

   // Strobe lands LATCH_LEAD clks before the fall predicted from the last phase.
   assign target  = (hi_len <= LEAD) ? ONE : hi_len - LEAD;
   assign pre_hit = target - ONE;

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         hi_count <= '0;
         hi_len   <= '0;
      end else begin
         if (phi_rise)
            hi_count <= ONE;
         else if (phi && hi_count != '1)
            hi_count <= hi_count + ONE;
         if (phi_fall && state != SYNC)
            hi_len <= hi_count;
      end
   end

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state       <= SYNC;
         core_ce     <= 1'b0;
         bus_oe      <= BUS_OE_RST;
         bus_r_w     <= BUS_R_W_RST;
         rd_strobe   <= 1'b0;
         cycle_abort <= 1'b0;
      end else begin
         core_ce     <= 1'b0;
         rd_strobe   <= 1'b0;
         cycle_abort <= 1'b0;
         unique case (state)
            SYNC: begin
               if (phi_fall)
                  state <= LOW;
            end
            LOW: begin
               if (phi_rise && aec_q) begin
                  state     <= OWN;
                  bus_oe    <= 1'b1;
                  bus_r_w   <= core_r_w;
                  rd_strobe <= core_r_w && (target == ONE);
               end else if (phi_rise) begin
                  state <= STALL;
               end
            end
            OWN: begin
               if (phi_fall) begin
                  state   <= LOW;
                  core_ce <= 1'b1;
                  bus_oe  <= BUS_OE_RST;
                  bus_r_w <= BUS_R_W_RST;
               end else if (!aec_q) begin
                  state       <= ABORT;
                  bus_oe      <= BUS_OE_RST;
                  bus_r_w     <= BUS_R_W_RST;
                  cycle_abort <= 1'b1;
               end else begin
                  rd_strobe <= bus_r_w && (hi_count == pre_hit);
               end
            end
            STALL, ABORT: begin
               if (phi_fall)
                  state <= LOW;
            end
            default: state <= SYNC;
         endcase
      end
   end

`ifdef STALL_STATS_EN
   logic stall_done;

   assign stall_done = phi_fall && (state == STALL || state == ABORT);

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset)
         stall_cnt <= '0;
      else if (stall_done && stall_cnt != '1)
         stall_cnt <= stall_cnt + STALL_W'(1);
   end
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_cycle_sched.sv
// tb_bus_cycle_sched: drives phi0/aec per bus cycle and scores
// each cycle's observed outputs against a queued expectation.
module tb_bus_cycle_sched;

   localparam int STALL_W = 10;
   localparam int SAT     = 1023;
`ifdef STALL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic _reset, phi0_in, aec, core_r_w;
   logic core_ce, bus_oe, bus_r_w, rd_strobe, cycle_abort;
   logic [STALL_W-1:0] stall_cnt;

   bus_cycle_sched dut (
      .clk         (clk),
      ._reset      (_reset),
      .phi0_in     (phi0_in),
      .aec         (aec),
      .core_r_w    (core_r_w),
      .core_ce     (core_ce),
      .bus_oe      (bus_oe),
      .bus_r_w     (bus_r_w),
      .rd_strobe   (rd_strobe),
      .cycle_abort (cycle_abort),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ce;
      int nstr;
      int spos;
      int ab;
      int oe;
      int rw0;
      int stall;
   } exp_t;

   exp_t sb[$];
   int checks = 0, failures = 0;
   int w_ce = 0, w_str = 0, w_spos = 0, w_ab = 0, w_oe = 0, w_rw0 = 0;
   int oe_run = 0;
   bit m_sync = 1'b1;
   int m_len = 0, m_stall = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus_oe) oe_run++;
      else oe_run = 0;
      if (core_ce) w_ce++;
      if (rd_strobe) begin
         w_str++;
         w_spos = oe_run;
      end
      if (cycle_abort) w_ab++;
      if (bus_oe) w_oe++;
      if (!bus_r_w) w_rw0++;
   end

   function automatic int sat_inc(input int v);
      return (v < SAT) ? v + 1 : SAT;
   endfunction

   // One phi0 cycle: hi/lo in clks, aec at rise, R/W, aec drop
   // index in the high phase (-1 none), reset at oe_run (0 none).
   task automatic bus_cycle(input int hi, input int lo, input logic a,
                            input logic rw, input int drop,
                            input int rst_at, input string tag);
      exp_t e, g;
      int   tgt, rst_i;
      bit   rst_done;
      e = '{default: 0};
      rst_done = 1'b0;
      rst_i = 0;
      tgt = (m_len <= 2) ? 1 : m_len - 2;
      if (rst_at > 0) begin
         e.oe = rst_at;
         e.rw0 = rw ? 0 : rst_at;
         m_stall = 0;
         m_len = 0;
         m_sync = 1'b0;
      end else if (m_sync) begin
         m_sync = 1'b0;
      end else if (!a) begin
         m_stall = sat_inc(m_stall);
         m_len = (hi > 63) ? 63 : hi;
      end else if (drop >= 0 && drop < hi) begin
         e.ab = 1;
         e.oe = drop;
         e.rw0 = rw ? 0 : drop;
         if (rw && tgt <= drop) begin
            e.nstr = 1;
            e.spos = tgt;
         end
         m_stall = sat_inc(m_stall);
         m_len = (hi > 63) ? 63 : hi;
      end else begin
         e.ce = 1;
         e.oe = hi;
         e.rw0 = rw ? 0 : hi;
         if (rw) begin
            e.nstr = 1;
            e.spos = tgt;
         end
         m_len = (hi > 63) ? 63 : hi;
      end
      e.stall = STATS ? m_stall : 0;
      sb.push_back(e);

      w_ce = 0; w_str = 0; w_spos = 0; w_ab = 0; w_oe = 0; w_rw0 = 0;
      aec = a;
      core_r_w = rw;
      phi0_in = 1'b1;
      for (int i = 1; i <= hi; i++) begin
         @(negedge clk); #1;
         if (i == drop) aec = 1'b0;
         if (rst_at > 0 && !rst_done && oe_run == rst_at) begin
            _reset = 1'b0;
            rst_done = 1'b1;
            rst_i = i;
            #1;
            check({tag, ".rst_oe"}, bus_oe, 0);
            check({tag, ".rst_rw"}, bus_r_w, 1);
            check({tag, ".rst_ce"}, core_ce, 0);
         end else if (rst_done && !_reset && i == rst_i + 2) begin
            _reset = 1'b1;
         end
      end
      phi0_in = 1'b0;
      for (int i = 0; i < lo; i++) begin
         @(negedge clk); #1;
      end

      g = sb.pop_front();
      check({tag, ".ce"}, w_ce, g.ce);
      check({tag, ".nstr"}, w_str, g.nstr);
      if (g.nstr == 1) check({tag, ".spos"}, w_spos, g.spos);
      check({tag, ".abort"}, w_ab, g.ab);
      check({tag, ".oe"}, w_oe, g.oe);
      check({tag, ".rw0"}, w_rw0, g.rw0);
      check({tag, ".stall"}, stall_cnt, g.stall);
   endtask

   initial begin
      _reset = 1'b0;
      phi0_in = 1'b0;
      aec = 1'b1;
      core_r_w = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset.ce", core_ce, 0);
      check("reset.oe", bus_oe, 0);
      check("reset.rw", bus_r_w, 1);
      check("reset.str", rd_strobe, 0);
      check("reset.abort", cycle_abort, 0);
      check("reset.stall", stall_cnt, 0);
      _reset = 1'b1;
      @(negedge clk); #1;

      bus_cycle(16, 16, 1'b1, 1'b1, -1, 0, "sync");
      bus_cycle(16, 16, 1'b1, 1'b1, -1, 0, "rd_first");
      for (int k = 0; k < 3; k++)
         bus_cycle(16, 16, 1'b1, 1'b1, -1, 0, "rd");
      bus_cycle(16, 16, 1'b1, 1'b0, -1, 0, "wr");
      bus_cycle(16, 16, 1'b1, 1'b0, -1, 0, "wr2");
      for (int k = 0; k < 3; k++)
         bus_cycle(16, 16, 1'b0, 1'b1, -1, 0, "stall");
      bus_cycle(16, 16, 1'b1, 1'b1, 5, 0, "abort");
      bus_cycle(16, 16, 1'b1, 1'b1, -1, 0, "retry");
      bus_cycle(16, 16, 1'b1, 1'b1, 16, 0, "fall_wins");
      bus_cycle(16, 16, 1'b1, 1'b1, -1, 0, "after_fw");
      for (int k = 0; k < 1030; k++)
         bus_cycle(8, 8, 1'b0, 1'b1, -1, 0, "sat");
      bus_cycle(16, 16, 1'b1, 1'b1, -1, 0, "rd_len8");
      bus_cycle(16, 16, 1'b1, 1'b0, -1, 8, "rst_mid");
      bus_cycle(16, 16, 1'b1, 1'b1, -1, 0, "post_rst");
      bus_cycle(16, 16, 1'b1, 1'b1, -1, 0, "post_rst2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
